// File: rtl/mem_pkg.sv
// Shared definitions for the data memory load/store paths: access size
// encodings, row geometry and the load FSM state type.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  localparam int ROW_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_CAP   = 3'd3,
    ST_RESP  = 3'd4
  } load_state_t;

endpackage

// File: rtl/load_align_extend.sv
// Combinational load aligner: picks the addressed little-endian bytes out of
// a {hi,lo} row pair and sign- or zero-extends them to 64 bits.
module load_align_extend
  import mem_pkg::*;
(
  input  logic [63:0] lo,
  input  logic [63:0] hi,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] result
);

  logic [127:0] w_cat;
  logic [127:0] w_shift;
  logic [63:0]  w_low;

  assign w_cat   = {hi, lo};
  assign w_shift = w_cat >> {off, 3'b000};
  assign w_low   = w_shift[63:0];

  // Keep nbytes*8 bits and fill the upper bits with the sign or with zero.
  always_comb begin
    result = w_low;
    case (size)
      SZ_BYTE:   result = {{56{~is_unsigned & w_low[7]}},  w_low[7:0]};
      SZ_HALF:   result = {{48{~is_unsigned & w_low[15]}}, w_low[15:0]};
      SZ_WORD:   result = {{32{~is_unsigned & w_low[31]}}, w_low[31:0]};
      SZ_DOUBLE: result = w_low;
      default:   result = w_low;
    endcase
  end

endmodule

// File: rtl/data_memory_load.sv
// Load path for the byte-lane data memory: accepts one request, issues one or
// two row reads (two when the access straddles a row boundary), then returns
// the aligned and extended result over a valid/ready response.
module data_memory_load
  import mem_pkg::*;
#(
  parameter int BYTE_ADDR_W = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [63:0]            req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  output logic                   mem_rd_en,
  output logic [BYTE_ADDR_W-4:0] mem_row_addr,
  input  logic [63:0]            mem_rd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [63:0]            rsp_data
);

  localparam int ROW_W = BYTE_ADDR_W - 3;

  load_state_t      r_state;
  logic [ROW_W-1:0] r_row;
  logic [2:0]       r_off;
  logic [1:0]       r_size;
  logic             r_uns;
  logic             r_cross;
  logic [63:0]      r_lo;
  logic             r_req_ready;
  logic             r_mem_rd_en;
  logic [ROW_W-1:0] r_mem_row_addr;
  logic             r_rsp_valid;
  logic [63:0]      r_rsp_data;

  load_state_t      w_state_nxt;
  logic             w_accept;
  logic [ROW_W-1:0] w_row;
  logic [2:0]       w_off;
  logic [3:0]       w_nbytes;
  logic             w_cross;
  logic [ROW_W-1:0] w_row_inc;
  logic [63:0]      w_lo;
  logic [63:0]      w_hi;
  logic [63:0]      w_result;

  assign w_accept  = req_valid & r_req_ready;
  assign w_row     = req_addr[BYTE_ADDR_W-1:3];
  assign w_off     = req_addr[2:0];
  assign w_nbytes  = 4'd1 << req_size;
  assign w_cross   = (({1'b0, w_off} + w_nbytes) > 4'd8);
  // Row index arithmetic wraps naturally at the top of the address space.
  assign w_row_inc = r_row + {{(ROW_W-1){1'b0}}, 1'b1};

  // In CAP the memory presents lo (single row) or hi (second row of a crossing).
  assign w_lo = r_cross ? r_lo : mem_rd_data;
  assign w_hi = r_cross ? mem_rd_data : 64'd0;

  load_align_extend u_align (
    .lo          (w_lo),
    .hi          (w_hi),
    .off         (r_off),
    .size        (r_size),
    .is_unsigned (r_uns),
    .result      (w_result)
  );

  // Next-state selection for the single-request load sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_accept ? ST_RD_LO : ST_IDLE;
      ST_RD_LO: w_state_nxt = r_cross ? ST_RD_HI : ST_CAP;
      ST_RD_HI: w_state_nxt = ST_CAP;
      ST_CAP:   w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched request fields and registered outputs; rst wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_row          <= '0;
      r_off          <= 3'd0;
      r_size         <= 2'd0;
      r_uns          <= 1'b0;
      r_cross        <= 1'b0;
      r_lo           <= 64'd0;
      r_req_ready    <= 1'b1;
      r_mem_rd_en    <= 1'b0;
      r_mem_row_addr <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= 64'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_mem_rd_en <= (w_state_nxt == ST_RD_LO) || (w_state_nxt == ST_RD_HI);
      if (w_state_nxt == ST_RD_LO) begin
        r_mem_row_addr <= w_row;
      end else if (w_state_nxt == ST_RD_HI) begin
        r_mem_row_addr <= w_row_inc;
      end else begin
        r_mem_row_addr <= '0;
      end
      if (w_accept) begin
        r_row   <= w_row;
        r_off   <= w_off;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_cross <= w_cross;
      end
      if (r_state == ST_RD_HI) begin
        r_lo <= mem_rd_data;
      end
      if (r_state == ST_CAP) begin
        r_rsp_data  <= w_result;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign mem_rd_en    = r_mem_rd_en;
  assign mem_row_addr = r_mem_row_addr;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;

endmodule

// File: tb/tb_data_memory_load.sv
// Directed self-checking bench for data_memory_load with a 1-cycle-latency
// row memory model.
module tb_data_memory_load;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_rd_en;
  logic [20:0] mem_row_addr;
  logic [63:0] mem_rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;

  int errors = 0;
  int checks = 0;

  data_memory_load dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_rd_en    (mem_rd_en),
    .mem_row_addr (mem_row_addr),
    .mem_rd_data  (mem_rd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_row(input logic [20:0] r);
    case (r)
      21'h000000: mem_row = 64'h8877665544332211;
      21'h000001: mem_row = 64'hFFEEDDCCBBAA9988;
      21'h1FFFFF: mem_row = 64'hA54B3C2D1E0F0102;
      default:    mem_row = 64'd0;
    endcase
  endfunction

  // Row memory: data appears the cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_row(mem_row_addr);
    else           mem_rd_data <= 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] exp, input int exp_lat,
                         input logic exp_cross, input logic [20:0] exp_r0,
                         input logic [20:0] exp_r1);
    int n;
    int pulses;
    logic [20:0] r0;
    logic [20:0] r1;
    logic done;
    n = 0; pulses = 0; r0 = '0; r1 = '0; done = 1'b0;
    @(negedge clk);
    req_addr = addr; req_size = size; req_unsigned = uns; req_valid = 1'b1;
    check({tag, "_req_ready_idle"}, {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!done && n < 20) begin
      if (mem_rd_en) begin
        pulses++;
        if (pulses == 1) r0 = mem_row_addr;
        else             r1 = mem_row_addr;
      end
      if (rsp_valid) done = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_rsp_seen"}, {63'd0, done}, 64'd1);
    check({tag, "_data"}, rsp_data, exp);
    check({tag, "_latency"}, 64'(n + 1), 64'(exp_lat));
    check({tag, "_rd_pulses"}, 64'(pulses), exp_cross ? 64'd2 : 64'd1);
    check({tag, "_row0"}, {43'd0, r0}, {43'd0, exp_r0});
    if (exp_cross) check({tag, "_row1"}, {43'd0, r1}, {43'd0, exp_r1});
    check({tag, "_req_ready_busy"}, {63'd0, req_ready}, 64'd0);
    if (rsp_ready) begin
      @(posedge clk); #1;
      check({tag, "_rsp_cleared"}, {63'd0, rsp_valid}, 64'd0);
      check({tag, "_back_idle"}, {63'd0, req_ready}, 64'd1);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_addr = 64'd0; req_size = 2'd0;
    req_unsigned = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("rst_row", {43'd0, mem_row_addr}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;

    do_load("dbl0",   64'h0, 2'b11, 1'b0, 64'h8877665544332211, 3, 1'b0, 21'h0, 21'h0);
    do_load("b7s",    64'h7, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFF88, 3, 1'b0, 21'h0, 21'h0);
    do_load("b7u",    64'h7, 2'b00, 1'b1, 64'h0000000000000088, 3, 1'b0, 21'h0, 21'h0);
    do_load("w6s",    64'h6, 2'b10, 1'b0, 64'hFFFFFFFF99888877, 4, 1'b1, 21'h0, 21'h1);
    do_load("h1u",    64'h1, 2'b01, 1'b1, 64'h0000000000003322, 3, 1'b0, 21'h0, 21'h0);
    do_load("h6s",    64'h6, 2'b01, 1'b0, 64'hFFFFFFFFFFFF8877, 3, 1'b0, 21'h0, 21'h0);
    do_load("w4u",    64'h4, 2'b10, 1'b1, 64'h0000000088776655, 3, 1'b0, 21'h0, 21'h0);
    do_load("dbl4",   64'h4, 2'b11, 1'b1, 64'hBBAA998888776655, 4, 1'b1, 21'h0, 21'h1);
    do_load("hwrap",  64'hFFFF_FFFF_00FF_FFFF, 2'b01, 1'b0, 64'h00000000000011A5, 4, 1'b1,
            21'h1FFFFF, 21'h0);
    do_load("btops",  64'hFFFFFF, 2'b00, 1'b0, 64'hFFFFFFFFFFFFFFA5, 3, 1'b0, 21'h1FFFFF, 21'h0);
    do_load("btopu",  64'hFFFFFF, 2'b00, 1'b1, 64'h00000000000000A5, 3, 1'b0, 21'h1FFFFF, 21'h0);

    // Backpressure: response held, concurrent requests must be ignored.
    rsp_ready = 1'b0;
    do_load("bp", 64'h8, 2'b11, 1'b0, 64'hFFEEDDCCBBAA9988, 3, 1'b0, 21'h1, 21'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_addr = 64'h0; req_size = 2'b11;
      @(posedge clk); #1;
      check("bp_valid_hold", {63'd0, rsp_valid}, 64'd1);
      check("bp_data_hold", rsp_data, 64'hFFEEDDCCBBAA9988);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      check("bp_no_read", {63'd0, mem_rd_en}, 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {63'd0, rsp_valid}, 64'd0);
    check("bp_release_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;
    check("bp_not_queued", {63'd0, mem_rd_en}, 64'd0);

    // Reset in RD_HI drops the request.
    @(negedge clk);
    req_addr = 64'h6; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rsthi_rd_en", {63'd0, mem_rd_en}, 64'd1);
    check("rsthi_row", {43'd0, mem_row_addr}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rsthi_req_ready", {63'd0, req_ready}, 64'd1);
    check("rsthi_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rsthi_rd_en_off", {63'd0, mem_rd_en}, 64'd0);
    check("rsthi_row_zero", {43'd0, mem_row_addr}, 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || mem_rd_en) seen++;
    end
    check("rsthi_no_response", 64'(seen), 64'd0);

    do_load("after_rst", 64'h9, 2'b01, 1'b1, 64'h000000000000AA99, 3, 1'b0, 21'h1, 21'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
